// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the keypad-driven MM:SS timer.
//   state_t      - sequencing FSM state encoding (exported on state_o)
//   KEY_*        - keypad command codes (code = 4*row + col)
//   DIG_*_LSB    - bit offsets of each BCD digit in {M10,M1,S10,S1}
//   DEF_*        - parameter defaults derived from a 4 MHz system clock
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_PAUSE = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam int DIG_S1_LSB  = 0;
  localparam int DIG_S10_LSB = 4;
  localparam int DIG_M1_LSB  = 8;
  localparam int DIG_M10_LSB = 12;

  localparam int DEF_SCAN_DIV       = 4000;      // 1 kHz column step
  localparam int DEF_DEBOUNCE_SCANS = 4;
  localparam int DEF_ALARM_CYCLES   = 12000000;  // 3 s

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x4 keypad columns one-hot, samples the rows at
// the end of each column dwell, and debounces whole-scan results into a single
// key event per press (no auto-repeat).
//   clk, rst_n  - clock, asynchronous active-low reset
//   row         - row sense, active high
//   col         - one-hot column drive
//   key_valid   - 1-cycle strobe on the last cycle of the accepting scan
//   key_code    - 4*row + col of the accepted key, valid with key_valid
module keypad_scanner #(
  parameter int SCAN_DIV       = 4000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [DW-1:0] dwell_cnt_reg;
  logic [1:0]    col_idx_reg;
  logic          hit_reg;
  logic [3:0]    hit_code_reg;
  logic          pressed_reg, pressed_next;
  logic [3:0]    cand_code_reg, cand_code_next;
  logic [CW-1:0] deb_cnt_reg, deb_cnt_next;

  logic          dwell_end, scan_end;
  logic [1:0]    row_idx;
  logic          res_hit;
  logic [3:0]    res_code;
  logic [CW-1:0] cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg == 2'(gi));
    end
  endgenerate

  assign dwell_end = (dwell_cnt_reg == DW'(SCAN_DIV - 1));
  assign scan_end  = dwell_end && (col_idx_reg == 2'd3);

  // Lowest active row wins within a column.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row[i]) row_idx = 2'(i);
    end
  end

  // Scan result includes the sample taken in the final dwell of the scan.
  assign res_hit  = hit_reg || (dwell_end && (|row));
  assign res_code = hit_reg ? hit_code_reg : {row_idx, col_idx_reg};
  assign key_code = res_code;

  always_comb begin
    pressed_next   = pressed_reg;
    cand_code_next = cand_code_reg;
    deb_cnt_next   = deb_cnt_reg;
    key_valid      = 1'b0;
    cnt_inc        = '0;
    if (scan_end) begin
      if (!pressed_reg) begin
        if (res_hit) begin
          if ((deb_cnt_reg != '0) && (res_code == cand_code_reg)) begin
            cnt_inc = deb_cnt_reg + 1'b1;
          end else begin
            cand_code_next = res_code;
            cnt_inc        = CW'(1);
          end
          if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
            key_valid    = 1'b1;
            pressed_next = 1'b1;
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = cnt_inc;
          end
        end else begin
          deb_cnt_next = '0;
        end
      end else begin
        // Any key seen while pressed restarts the release count.
        if (!res_hit) begin
          if ((deb_cnt_reg + 1'b1) >= CW'(DEBOUNCE_SCANS)) begin
            pressed_next = 1'b0;
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
          end
        end else begin
          deb_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt_reg <= '0;
      col_idx_reg   <= 2'd0;
      hit_reg       <= 1'b0;
      hit_code_reg  <= 4'd0;
      pressed_reg   <= 1'b0;
      cand_code_reg <= 4'd0;
      deb_cnt_reg   <= '0;
    end else begin
      dwell_cnt_reg <= dwell_end ? '0 : dwell_cnt_reg + 1'b1;
      if (dwell_end) col_idx_reg <= col_idx_reg + 2'd1;
      if (scan_end) begin
        hit_reg <= 1'b0;
      end else if (dwell_end && (|row) && !hit_reg) begin
        hit_reg      <= 1'b1;
        hit_code_reg <= {row_idx, col_idx_reg};
      end
      pressed_reg   <= pressed_next;
      cand_code_reg <= cand_code_next;
      deb_cnt_reg   <= deb_cnt_next;
    end
  end

endmodule

// File: rtl/keypad_timer_ctrl.sv
// keypad_timer_ctrl: keypad-driven sequencing controller for the MM:SS BCD
// down-counter. Collects digit keys into a 4-digit preset, validates it on
// START, drives load/run into the counter and raises a timed alarm on expiry.
//   clk, rst_n - clock, asynchronous active-low reset
//   row / col  - keypad row sense in, one-hot column drive out
//   zero       - counter reports 00:00
//   load       - 1-cycle load pulse, counter takes load_bcd
//   load_bcd   - preset {M10,M1,S10,S1}
//   run        - counter decrement enable
//   alarm      - expiry indication
//   entry_bcd  - digits being entered, for display
//   state_o    - FSM state, for debug
module keypad_timer_ctrl
  import timer_pkg::*;
#(
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int ALARM_CYCLES   = DEF_ALARM_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        zero,
  output logic        load,
  output logic [15:0] load_bcd,
  output logic        run,
  output logic        alarm,
  output logic [15:0] entry_bcd,
  output logic [2:0]  state_o
);

  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  state_t        state_reg, state_next;
  logic [15:0]   entry_reg, entry_next;
  logic          load_reg, load_next;
  logic [15:0]   load_bcd_reg, load_bcd_next;
  logic          run_reg, run_next;
  logic          alarm_reg, alarm_next;
  logic [AW-1:0] alarm_cnt_reg, alarm_cnt_next;

  logic       key_valid;
  logic [3:0] key_code;
  logic       entry_ok, zero_seen;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign entry_ok = (entry_reg != 16'd0) &&
                    (entry_reg[DIG_S10_LSB +: 4] <= 4'd5) &&
                    (entry_reg[DIG_M10_LSB +: 4] <= 4'd9);

  // During the load cycle the counter still shows its previous value (often
  // 00:00 after an expiry), so zero is only trusted once the load has landed.
  assign zero_seen = zero && !load_reg;

  always_comb begin
    state_next     = state_reg;
    entry_next     = entry_reg;
    load_next      = 1'b0;
    load_bcd_next  = load_bcd_reg;
    run_next       = run_reg;
    alarm_next     = alarm_reg;
    alarm_cnt_next = alarm_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (key_valid && is_digit(key_code)) begin
          entry_next = {entry_reg[11:0], key_code};
          state_next = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            entry_next = {entry_reg[11:0], key_code};
          end else if (key_code == KEY_CLEAR) begin
            entry_next = 16'd0;
            state_next = ST_IDLE;
          end else if ((key_code == KEY_START) && entry_ok) begin
            load_next     = 1'b1;
            load_bcd_next = entry_reg;
            state_next    = ST_RUN;
          end
        end
      end
      ST_RUN, ST_PAUSE: begin
        // RUN holds run high; the first RUN cycle after a load raises it.
        run_next = (state_reg == ST_RUN);
        if ((state_reg == ST_RUN) && zero_seen) begin
          run_next       = 1'b0;
          alarm_next     = 1'b1;
          alarm_cnt_next = AW'(ALARM_CYCLES - 1);
          state_next     = ST_DONE;
        end else if (key_valid) begin
          if (key_code == KEY_CLEAR) begin
            run_next      = 1'b0;
            load_next     = 1'b1;
            load_bcd_next = 16'd0;
            entry_next    = 16'd0;
            state_next    = ST_IDLE;
          end else if ((state_reg == ST_RUN) && (key_code == KEY_PAUSE)) begin
            run_next   = 1'b0;
            state_next = ST_PAUSE;
          end else if ((state_reg == ST_PAUSE) && (key_code == KEY_START)) begin
            run_next   = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        run_next = 1'b0;
        if (key_valid || (alarm_cnt_reg == '0)) begin
          alarm_next = 1'b0;
          entry_next = 16'd0;
          state_next = ST_IDLE;
        end else begin
          alarm_cnt_next = alarm_cnt_reg - 1'b1;
        end
      end
      default: begin
        run_next   = 1'b0;
        alarm_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      entry_reg     <= 16'd0;
      load_reg      <= 1'b0;
      load_bcd_reg  <= 16'd0;
      run_reg       <= 1'b0;
      alarm_reg     <= 1'b0;
      alarm_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      entry_reg     <= entry_next;
      load_reg      <= load_next;
      load_bcd_reg  <= load_bcd_next;
      run_reg       <= run_next;
      alarm_reg     <= alarm_next;
      alarm_cnt_reg <= alarm_cnt_next;
    end
  end

  assign load      = load_reg;
  assign load_bcd  = load_bcd_reg;
  assign run       = run_reg;
  assign alarm     = alarm_reg;
  assign entry_bcd = entry_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_keypad_timer_ctrl.sv
module tb_keypad_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        zero;
  logic        load;
  logic [15:0] load_bcd;
  logic        run;
  logic        alarm;
  logic [15:0] entry_bcd;
  logic [2:0]  state_o;

  logic        held_en   = 1'b0;
  logic [3:0]  held_code = 4'd0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          load_cnt  = 0;
  int          acnt;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_RUN = 3'd2,
                         S_PAUSE = 3'd3, S_DONE = 3'd4;

  keypad_timer_ctrl #(
    .SCAN_DIV       (2),
    .DEBOUNCE_SCANS (2),
    .ALARM_CYCLES   (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .zero      (zero),
    .load      (load),
    .load_bcd  (load_bcd),
    .run       (run),
    .alarm     (alarm),
    .entry_bcd (entry_bcd),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Keypad model: the held key connects its row to its column.
  assign row = (held_en && col[held_code[1:0]]) ? (4'b0001 << held_code[3:2]) : 4'b0000;

  always @(negedge clk) if (load) load_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Align to the negedge of the first cycle of a new scan (col0, dwell 0).
  task automatic wait_scan_start();
    logic [3:0] last;
    logic found;
    last  = col;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col == 4'b0001 && last == 4'b1000) begin
        found = 1'b1;
        break;
      end
      last = col;
    end
    if (!found) check("scan_sync", 32'd0, 32'd1);
  endtask

  // Hold a key from a scan start; return n cycles later with the key held.
  // The event lands in cycle 15, so register effects are visible at 16.
  task automatic key_down(input logic [3:0] code, input int n);
    wait_scan_start();
    held_code = code;
    held_en   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic key_up();
    held_en = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    key_down(code, 16);
    key_up();
  endtask

  initial begin
    rst_n = 1'b0;
    zero  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h1);
    check("rst_load", 32'(load), 32'h0);
    check("rst_load_bcd", 32'(load_bcd), 32'h0);
    check("rst_run", 32'(run), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_entry", 32'(entry_bcd), 32'h0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    rst_n = 1'b1;

    // Entry 1,2,3,0 then START
    key_down(4'd1, 15);
    check("lat_before", 32'(entry_bcd), 32'h0);
    @(negedge clk);
    check("lat_after", 32'(entry_bcd), 32'h1);
    check("entry_state", 32'(state_o), 32'(S_ENTRY));
    key_up();
    press(4'd2);
    press(4'd3);
    press(4'd0);
    check("entry_1230", 32'(entry_bcd), 32'h1230);
    key_down(4'hA, 16);
    check("start_load", 32'(load), 32'h1);
    check("start_load_bcd", 32'(load_bcd), 32'h1230);
    check("start_run_early", 32'(run), 32'h0);
    @(negedge clk);
    check("start_load_1cyc", 32'(load), 32'h0);
    check("start_run", 32'(run), 32'h1);
    check("start_state", 32'(state_o), 32'(S_RUN));
    key_up();
    check("load_count_1", 32'(load_cnt), 32'd1);

    // Pause, resume, clear
    key_down(4'hB, 16);
    check("pause_run", 32'(run), 32'h0);
    check("pause_state", 32'(state_o), 32'(S_PAUSE));
    key_up();
    press(4'd9);
    check("pause_digit_ignored", 32'(entry_bcd), 32'h1230);
    key_down(4'hA, 16);
    check("resume_run", 32'(run), 32'h1);
    check("resume_state", 32'(state_o), 32'(S_RUN));
    key_up();
    check("resume_no_load", 32'(load_cnt), 32'd1);
    key_down(4'hC, 16);
    check("clear_load", 32'(load), 32'h1);
    check("clear_load_bcd", 32'(load_bcd), 32'h0);
    check("clear_run", 32'(run), 32'h0);
    check("clear_entry", 32'(entry_bcd), 32'h0);
    check("clear_state", 32'(state_o), 32'(S_IDLE));
    key_up();

    // Rejected preset (S10=7)
    press(4'd0);
    press(4'd0);
    press(4'd7);
    press(4'd0);
    check("entry_0070", 32'(entry_bcd), 32'h0070);
    key_down(4'hA, 16);
    check("reject_load", 32'(load), 32'h0);
    check("reject_state", 32'(state_o), 32'(S_ENTRY));
    key_up();
    check("load_count_2", 32'(load_cnt), 32'd2);
    press(4'hC);
    check("cancel_entry", 32'(entry_bcd), 32'h0);
    check("cancel_state", 32'(state_o), 32'(S_IDLE));

    // One-scan glitch, then a long hold
    key_down(4'd5, 8);
    key_up();
    check("glitch_entry", 32'(entry_bcd), 32'h0);
    check("glitch_state", 32'(state_o), 32'(S_IDLE));
    key_down(4'd5, 80);
    key_up();
    check("hold10_entry", 32'(entry_bcd), 32'h0005);
    press(4'hC);

    // Expiry: full-length alarm
    press(4'd1);
    press(4'hA);
    check("run2_run", 32'(run), 32'h1);
    zero = 1'b1;
    @(negedge clk);
    check("zero_run", 32'(run), 32'h0);
    check("zero_alarm", 32'(alarm), 32'h1);
    check("zero_state", 32'(state_o), 32'(S_DONE));
    acnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alarm) acnt++;
      else break;
    end
    check("alarm_len", 32'(acnt), 32'd20);
    check("alarm_end_state", 32'(state_o), 32'(S_IDLE));
    check("alarm_end_entry", 32'(entry_bcd), 32'h0);
    zero = 1'b0;

    // Expiry cut short by a key event
    press(4'd2);
    press(4'hA);
    check("run3_run", 32'(run), 32'h1);
    key_down(4'd7, 6);
    zero = 1'b1;
    acnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alarm) acnt++;
      else if (acnt > 0) break;
    end
    check("alarm_key_len", 32'(acnt), 32'd9);
    check("alarm_key_state", 32'(state_o), 32'(S_IDLE));
    zero = 1'b0;
    key_up();
    check("no_repeat_entry", 32'(entry_bcd), 32'h0);
    check("no_repeat_state", 32'(state_o), 32'(S_IDLE));

    // Asynchronous reset during RUN with a key held
    press(4'd3);
    press(4'hA);
    check("run4_run", 32'(run), 32'h1);
    key_down(4'd4, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_col", 32'(col), 32'h1);
    check("arst_run", 32'(run), 32'h0);
    check("arst_load_bcd", 32'(load_bcd), 32'h0);
    check("arst_entry", 32'(entry_bcd), 32'h0);
    check("arst_state", 32'(state_o), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_lat_before", 32'(entry_bcd), 32'h0);
    @(negedge clk);
    check("arst_lat_after", 32'(entry_bcd), 32'h0004);
    key_up();
    check("arst_one_event", 32'(entry_bcd), 32'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_timer_ctrl.md
# keypad_timer_ctrl

Sequencing controller for the MM:SS countdown timer. Scans the 4x4 matrix keypad, debounces it, and emits one key event per press. Assembles digit keys into a 4-digit BCD preset and drives load/run control into the BCD down-counter. Detects counter expiry and raises a timed alarm; it replaces DIP-switch digit selection as the timer's configuration path.

## Interface
Parameters:
- SCAN_DIV, 4000: clk cycles per keypad column dwell (1 kHz column step at 4 MHz).
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release.
- ALARM_CYCLES, 12000000: alarm duration in clk cycles (3 s at 4 MHz).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- row  in  4  keypad row sense; active high.
- col  out  4  keypad column drive; one-hot.
- zero  in  1  counter reports 00:00.
- load  out  1  one-cycle pulse; counter loads load_bcd.
- load_bcd  out  16  preset {M10,M1,S10,S1}; BCD.
- run  out  1  counter decrement enable.
- alarm  out  1  expiry indication.
- entry_bcd  out  16  digits currently being entered, for display.
- state_o  out  3  FSM state encoding, for debug.

## Operation
- Key map: col index c, row index r, code = 4r+c. Codes 0-9 are digits. 0xA=START, 0xB=PAUSE, 0xC=CLEAR. 0xD-0xF are ignored.
- Scan: col rotates 0001→0010→0100→1000→0001. row is sampled on the last cycle of each dwell. A scan is four dwells. Its result is the first active (col, row) in scan order, lowest row first within a column, or NONE.
- Debounce: a press is accepted when the same code is seen for DEBOUNCE_SCANS consecutive scans while released. This produces exactly one key event, a 1-cycle internal strobe. A release is accepted after DEBOUNCE_SCANS consecutive NONE scans. Auto-repeat is not allowed.
- FSM states are IDLE, ENTRY, RUN, PAUSE and DONE.
- IDLE: a digit sets entry={entry[11:0],d} and moves to ENTRY. Other keys are ignored.
- ENTRY:
  - digit: shift as above; older digits fall off the top.
  - CLEAR: entry=0, go to IDLE.
  - START: accepted only if entry≠0 and S10≤5 and M10≤9. On accept, load=1 for one cycle with load_bcd=entry, then run=1 from the next cycle, state RUN. On reject, stay in ENTRY.
- RUN:
  - PAUSE: run=0, go to PAUSE.
  - CLEAR: run=0, load pulse with load_bcd=0, entry=0, go to IDLE.
  - zero=1: run=0, alarm=1, go to DONE.
- PAUSE: START resumes RUN with no load. CLEAR behaves as in RUN. Digits are ignored.
- DONE: alarm stays high until ALARM_CYCLES elapse or any key event arrives. Either exit goes to IDLE with entry=0.
- Simultaneous events: zero wins over any key event in the same cycle.

## Timing
- Reset values: col=0001, load=0, load_bcd=0, run=0, alarm=0, entry_bcd=0, state IDLE. Scan divider and debounce counters are 0.
- Reset mid-operation: all of the above take effect immediately (asynchronous). The counter is not reloaded.
- Key latency: press at row, then the event fires on the last cycle of the DEBOUNCE_SCANS-th matching scan.
- Output timing:
  - load is registered and asserts the cycle after the START event.
  - run asserts the cycle after load.
  - In PAUSE→RUN, run asserts the cycle after the START event.
- zero is sampled every cycle in RUN. run deasserts the cycle after zero is seen.
- Alarm counter: ALARM_CYCLES-1 down to 0; alarm deasserts at terminal count. Width is $clog2(ALARM_CYCLES).
- Dwell counter width is $clog2(SCAN_DIV). Debounce counter saturates at DEBOUNCE_SCANS.

## Structure
- Package timer_pkg holds:
  - the state enum;
  - key code constants KEY_START/KEY_PAUSE/KEY_CLEAR;
  - the BCD digit-field index constants;
  - the default-clock-derived parameter values.
- Sub-module keypad_scanner: col drive, row sampling, debounce. Its outputs are key_valid (1-cycle) and key_code[3:0].
- The top holds the FSM, entry register, validation, alarm timer and counter interface.

## Test plan
Simulate with SCAN_DIV=2, DEBOUNCE_SCANS=2, ALARM_CYCLES=20.
- Press keys 1,2,3,0, then A → entry_bcd=0x1230, one load pulse with load_bcd=0x1230, run=1 the next cycle.
- Entry 0x0070 + A → rejected, no load, stays ENTRY. Then C → entry_bcd=0, IDLE.
- A row glitch of one scan only → no key event. A press held 10 scans → exactly one event.
- RUN, press B → run=0 and PAUSE. Press A → run=1, no load. Press C → load with load_bcd=0, IDLE.
- RUN, zero=1 → run=0 next cycle, alarm high for 20 cycles, then IDLE. A second run where a key arrives mid-alarm → alarm clears on the event.
- Deassert rst_n during RUN with a key held → all outputs at reset values immediately, col=0001. After release, the held key produces one event after debounce.
